// File: rtl/uart_cmd_pkg.sv
// Shared types, ASCII constants and helpers for the UART command-line parser.
package uart_cmd_pkg;

    // Command opcodes as presented on cmd_op.
    typedef enum logic [1:0] {
        OP_JAL = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_ERR = 2'b11
    } op_e;

    // Parser FSM states.
    typedef enum logic [2:0] {
        S_WORD,
        S_SEP1,
        S_ARG1,
        S_SEP2,
        S_ARG2,
        S_TRAIL,
        S_EMIT,
        S_DISCARD
    } state_e;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    // ASCII byte to {valid, nibble}; accepts 0-9, a-f and A-F.
    function automatic logic [4:0] hex_val(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return {1'b1, 4'(c - 8'h30)};
        if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
        if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
        return 5'b0;
    endfunction

    // Collected command word (right-aligned, zero-padded) to {known, opcode}.
    function automatic logic [2:0] match_word(input logic [23:0] w);
        case (w)
            24'h6A616C: return {1'b1, OP_JAL};  // "jal"
            24'h006C77: return {1'b1, OP_LW};   // "lw"
            24'h007377: return {1'b1, OP_SW};   // "sw"
            default:    return {1'b0, OP_ERR};
        endcase
    endfunction

endpackage

// File: rtl/hex_accum.sv
// Digit-count-limited hex shift accumulator. full_o flags that the next digit
// would overflow the limit; such a load is refused so the caller can reject it.
module hex_accum #(
    parameter int unsigned MAX_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr_i,
    input  logic                    load_i,
    input  logic [3:0]              digit_i,
    output logic [4*MAX_DIGITS-1:0] value_o,
    output logic                    full_o
);
    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

    logic [4*MAX_DIGITS-1:0] value_q, value_d;
    logic [CW-1:0]           count_q, count_d;

    assign full_o  = (count_q == CW'(MAX_DIGITS));
    assign value_o = value_q;

    // Clear has priority; otherwise shift in one digit if room remains.
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clr_i) begin
            value_d = '0;
            count_d = '0;
        end else if (load_i && !full_o) begin
            value_d = (value_q << 4) | (4*MAX_DIGITS)'(digit_i);
            count_d = count_q + CW'(1);
        end
    end

    // Accumulator and digit-count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Tokenises CR-terminated ASCII command lines (jal/lw/sw + hex args) from the
// UART receiver and emits one decoded command per line over ready/valid.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned MAX_HEX_DIGITS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  data_in,
    input  logic        data_in_valid,
    output logic        data_in_ready,
    output logic [1:0]  cmd_op,
    output logic [31:0] cmd_addr,
    output logic [31:0] cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready
);
    state_e      state_q, state_d;
    logic [23:0] word_q, word_d;
    logic [1:0]  wlen_q, wlen_d;
    op_e         op_q, op_d;
    logic [31:0] hold_q, hold_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    op_e         cmd_op_q, cmd_op_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_data_q, cmd_data_d;

    logic                        acc_clr, acc_load, acc_full;
    logic [4*MAX_HEX_DIGITS-1:0] acc_value;
    logic [31:0]                 acc_value32;
    logic [4:0]                  hex;
    logic [2:0]                  word_m;
    logic                        is_cr, is_sp, is_lower, emit_ok, emit_err;

    assign hex         = hex_val(data_in);
    assign word_m      = match_word(word_q);
    assign is_cr       = (data_in == CHAR_CR);
    assign is_sp       = (data_in == CHAR_SP);
    assign is_lower    = (data_in >= 8'h61) && (data_in <= 8'h7A);
    assign acc_value32 = 32'(acc_value);

    // One accumulator serves both arguments; ARG1 moves to hold_q before ARG2.
    hex_accum #(.MAX_DIGITS(MAX_HEX_DIGITS)) u_accum (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (acc_clr),
        .load_i  (acc_load),
        .digit_i (hex[3:0]),
        .value_o (acc_value),
        .full_o  (acc_full)
    );

    // Next-state, token update and command capture for one accepted byte.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        word_d     = word_q;
        wlen_d     = wlen_q;
        op_d       = op_q;
        hold_d     = hold_q;
        valid_d    = valid_q;
        cmd_op_d   = cmd_op_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        acc_clr    = 1'b0;
        acc_load   = 1'b0;
        emit_ok    = 1'b0;
        emit_err   = 1'b0;

        if (state_q == S_EMIT) begin
            if (cmd_ready) begin
                state_d    = S_WORD;
                word_d     = '0;
                wlen_d     = '0;
                op_d       = OP_JAL;
                hold_d     = '0;
                acc_clr    = 1'b1;
                valid_d    = 1'b0;
                cmd_op_d   = OP_JAL;
                cmd_addr_d = '0;
                cmd_data_d = '0;
            end
        end else if (data_in_valid && ready_q && data_in != CHAR_LF) begin
            case (state_q)
                S_WORD: begin
                    if (is_cr) begin
                        emit_err = (wlen_q != 2'd0);  // empty line is silently dropped
                    end else if (is_sp) begin
                        if (wlen_q != 2'd0) begin
                            if (word_m[2]) begin
                                op_d    = op_e'(word_m[1:0]);
                                state_d = S_SEP1;
                            end else begin
                                state_d = S_DISCARD;
                            end
                        end
                    end else if (is_lower && wlen_q != 2'd3) begin
                        word_d = {word_q[15:0], data_in};
                        wlen_d = wlen_q + 2'd1;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
                S_SEP1, S_SEP2: begin
                    if (is_cr) begin
                        emit_err = 1'b1;
                    end else if (hex[4]) begin
                        acc_load = 1'b1;
                        state_d  = (state_q == S_SEP1) ? S_ARG1 : S_ARG2;
                    end else if (!is_sp) begin
                        state_d = S_DISCARD;
                    end
                end
                S_ARG1, S_ARG2: begin
                    if (hex[4]) begin
                        if (acc_full) state_d = S_DISCARD;
                        else          acc_load = 1'b1;
                    end else if (is_sp) begin
                        if (state_q == S_ARG1 && op_q == OP_SW) begin
                            hold_d  = acc_value32;
                            acc_clr = 1'b1;
                            state_d = S_SEP2;
                        end else begin
                            state_d = S_TRAIL;
                        end
                    end else if (is_cr) begin
                        if (state_q == S_ARG1 && op_q == OP_SW) emit_err = 1'b1;
                        else                                     emit_ok  = 1'b1;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
                S_TRAIL: begin
                    if (is_cr)       emit_ok = 1'b1;
                    else if (!is_sp) state_d = S_DISCARD;
                end
                S_DISCARD: begin
                    emit_err = is_cr;
                end
                default: ;
            endcase
        end

        if (emit_ok) begin
            state_d    = S_EMIT;
            valid_d    = 1'b1;
            cmd_op_d   = op_q;
            cmd_addr_d = acc_value32;
            cmd_data_d = (op_q == OP_SW) ? hold_q : 32'h0;
        end else if (emit_err) begin
            state_d    = S_EMIT;
            valid_d    = 1'b1;
            cmd_op_d   = OP_ERR;
            cmd_addr_d = '0;
            cmd_data_d = '0;
        end

        ready_d = (state_d != S_EMIT);
    end

    // State, token and registered output stage.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state_q    <= S_WORD;
            word_q     <= '0;
            wlen_q     <= '0;
            op_q       <= OP_JAL;
            hold_q     <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            cmd_op_q   <= OP_JAL;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            wlen_q     <= wlen_d;
            op_q       <= op_d;
            hold_q     <= hold_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            cmd_op_q   <= cmd_op_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
        end
    end

    assign data_in_ready = ready_q;
    assign cmd_valid     = valid_q;
    assign cmd_op        = cmd_op_q;
    assign cmd_addr      = cmd_addr_q;
    assign cmd_data      = cmd_data_q;

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Hardware command-line parser on the receive side of the on-chip UART. Consumes the ready/valid ASCII byte stream from `uart` `data_out`, tokenises BIOS-style lines such as `jal 10000000` terminated by CR, and emits one decoded command per line on a ready/valid command port. Sits between the UART receiver and a debug/boot controller so that the off-chip host can drive the design without CPU firmware.

## Interface

Parameters:
- `MAX_HEX_DIGITS`, default 8: maximum hex digits per argument; the argument register is `4*MAX_HEX_DIGITS` bits and zero-extended to 32.

Ports:
- `clk`  in  1  system clock (125 MHz)
- `reset_n`  in  1  asynchronous, active-low reset
- `data_in`  in  8  ASCII byte from the UART receiver
- `data_in_valid`  in  1  byte valid
- `data_in_ready`  out  1  parser accepts the byte this cycle
- `cmd_op`  out  2  00 JAL, 01 LW, 10 SW, 11 ERR
- `cmd_addr`  out  32  address argument
- `cmd_data`  out  32  data argument (SW only, else 0)
- `cmd_valid`  out  1  command available
- `cmd_ready`  in  1  consumer takes command

## Operation

- A byte transfers when `data_in_valid && data_in_ready`.
- Grammar: `jal <addr>`, `lw <addr>`, `sw <data> <addr>`, with a CR (0x0D) terminator. One or more spaces (0x20) separate tokens. Leading spaces are ignored. LF (0x0A) is ignored everywhere.
- Hex digits `0-9 a-f A-F` are accepted. Each digit shifts the argument left 4 and ORs in the digit value.
- FSM states:
  - WORD: collects up to 3 lowercase letters. On a space, matches `jal`/`lw`/`sw` and goes to SEP1, otherwise DISCARD.
  - SEP1: skips spaces; a hex digit goes to ARG1.
  - ARG1: accumulates digits. A space goes to SEP2 for SW, or to TRAIL for JAL/LW.
  - SEP2: skips spaces; a hex digit goes to ARG2.
  - ARG2: accumulates digits; a space goes to TRAIL.
  - TRAIL: accepts spaces only.
  - EMIT: presents the command.
  - DISCARD: swallows bytes until CR, then goes to EMIT with ERR.
- CR handling:
  - In ARG1 (JAL/LW), ARG2 (SW) or TRAIL: goes to EMIT with a valid op.
  - In WORD with 0 characters: blank line, no command; stays in WORD.
  - In any other state: goes to EMIT with ERR.
- Error causes, each of which goes to DISCARD (or straight to EMIT if the byte is CR):
  - unknown word, or word longer than 3 characters
  - a non-hex, non-space, non-CR character in an argument
  - more than `MAX_HEX_DIGITS` digits in one argument
  - an extra argument
  - a missing argument
- Argument mapping: for SW, ARG1 goes to `cmd_data` and ARG2 to `cmd_addr`. For JAL/LW, ARG1 goes to `cmd_addr` and `cmd_data` is 0. For ERR, both are 0.
- After the EMIT handshake, all token registers clear and the FSM returns to WORD.

## Timing

- Reset values: `data_in_ready`=0 while `reset_n` is low, 1 in the first cycle after release; `cmd_valid`=0, `cmd_op`=00, `cmd_addr`=0, `cmd_data`=0; FSM in WORD.
- `data_in_ready` is 1 in every state except EMIT. Throughput is one byte per cycle.
- Latency: `cmd_valid` rises on the clock edge after the CR transfer. Outputs are registered.
- `cmd_valid` stays high and `cmd_op`/`cmd_addr`/`cmd_data` stay stable until the cycle with `cmd_valid && cmd_ready`.
- `data_in_ready` returns to 1 in the cycle after the command handshake. No byte is dropped while in EMIT, because the receiver holds its byte under backpressure.
- `reset_n` asserted mid-line or mid-EMIT: immediately clears all state and outputs, and any partial command is lost.

## Structure

- Package `uart_cmd_pkg` holds:
  - op encodings `OP_JAL`, `OP_LW`, `OP_SW`, `OP_ERR`
  - FSM state enum
  - ASCII constants `CHAR_CR`, `CHAR_LF`, `CHAR_SP`
  - function `hex_val` (byte to {valid, nibble})
- One sub-module, `hex_accum`: a digit-count-limited shift accumulator with clear, load and overflow flag. It is instantiated once and reused for both arguments; ARG1 is latched into a holding register when SEP2 is entered.

## Test plan

- `jal 10000000\r` with `cmd_ready`=1: one command, op=00, addr=0x10000000, data=0. `cmd_valid` high exactly 1 cycle, starting 1 cycle after the CR transfer.
- `sw  CAFEf00d 80000010 \r\n`: op=10, data=0xCAFEF00D, addr=0x80000010. The trailing LF produces no command.
- `xyz 1\r`, then `lw 123456789\r`, then `jal\r`: three commands, each op=11 with addr=0 and data=0.
- `lw 4\r` with `cmd_ready`=0 for 20 cycles and the next line streamed immediately: outputs stable at op=01, addr=0x4; `data_in_ready`=0 throughout EMIT. After the handshake, the next line parses correctly.
- `\r\r`: no command emitted; `data_in_ready` stays 1.
- `jal 1000` then `reset_n` pulsed low mid-line, then `lw 8\r`: a single command with op=01, addr=0x8. All outputs are 0 during reset.
